// File: rtl/noc_cmd_parser.sv
// NOC receive-side command parser: decodes READ/WRITE frames into a write FIFO and a single read register.
// Optional saturating error counter built when NOC_PARSER_ERRCNT_EN is defined.
module noc_cmd_parser #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       noc_to_dev_ctl,
  input  logic [7:0] noc_to_dev_data,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_addr,
  output logic [3:0] rd_len,
  output logic       frame_err,
  output logic       fifo_ovf,
  output logic [7:0] err_count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WDATA} state_t;

  state_t     state_q, state_d;
  logic       is_wr_q, is_wr_d;
  logic [1:0] lcode_q, lcode_d;
  logic [7:0] base_q, base_d;
  logic [3:0] idx_q, idx_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic [3:0] rd_len_q, rd_len_d;
  logic       frame_err_q;
  logic       ovf_q;

  logic [7:0] fifo_addr_q [FIFO_DEPTH];
  logic [7:0] fifo_data_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  logic       empty, full, pop, push_req, push_ok, err_evt, ovf_evt;
  logic [3:0] len_cur;
  logic [7:0] push_addr;

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop       = !empty && wr_ready;
  assign push_ok   = push_req && (!full || pop);
  assign ovf_evt   = push_req && !push_ok;
  assign len_cur   = 4'd1 << lcode_q;
  assign push_addr = base_q + {4'd0, idx_q};

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    lcode_d    = lcode_q;
    base_d     = base_q;
    idx_d      = idx_q;
    rd_valid_d = rd_valid_q && !rd_ready;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    push_req   = 1'b0;
    err_evt    = 1'b0;
    if (noc_to_dev_ctl) begin
      // A command byte always restarts decoding; mid-frame it also aborts the frame.
      err_evt = (state_q != S_IDLE);
      state_d = S_IDLE;
      case (noc_to_dev_data[7:5])
        3'b000: ;
        3'b001, 3'b010: begin
          is_wr_d = noc_to_dev_data[6];
          lcode_d = noc_to_dev_data[1:0];
          state_d = S_ADDR;
        end
        default: err_evt = 1'b1;
      endcase
    end else begin
      case (state_q)
        S_IDLE: err_evt = 1'b1;
        S_ADDR: begin
          base_d = noc_to_dev_data;
          if (is_wr_q) begin
            idx_d   = 4'd0;
            state_d = S_WDATA;
          end else begin
            state_d = S_IDLE;
            if (rd_valid_q && !rd_ready) begin
              err_evt = 1'b1;
            end else begin
              rd_valid_d = 1'b1;
              rd_addr_d  = noc_to_dev_data;
              rd_len_d   = len_cur;
            end
          end
        end
        S_WDATA: begin
          push_req = 1'b1;
          idx_d    = idx_q + 4'd1;
          if (idx_q + 4'd1 == len_cur) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_addr_q   <= 8'h00;
      rd_len_q    <= 4'd0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_valid_q  <= rd_valid_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
      frame_err_q <= err_evt;
      if (ovf_evt) ovf_q <= 1'b1;
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop)     rptr_q <= rptr_q + 1'b1;
    end
  end

  // Datapath storage carries no reset; validity is tracked by the control registers.
  always_ff @(posedge clk) begin
    is_wr_q <= is_wr_d;
    lcode_q <= lcode_d;
    base_q  <= base_d;
    idx_q   <= idx_d;
    if (push_ok) begin
      fifo_addr_q[wptr_q[AW-1:0]] <= push_addr;
      fifo_data_q[wptr_q[AW-1:0]] <= noc_to_dev_data;
    end
  end

  assign wr_valid  = !empty;
  assign wr_addr   = empty ? 8'h00 : fifo_addr_q[rptr_q[AW-1:0]];
  assign wr_data   = empty ? 8'h00 : fifo_data_q[rptr_q[AW-1:0]];
  assign rd_valid  = rd_valid_q;
  assign rd_addr   = rd_addr_q;
  assign rd_len    = rd_len_q;
  assign frame_err = frame_err_q;
  assign fifo_ovf  = ovf_q;

`ifdef NOC_PARSER_ERRCNT_EN
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic b, input logic c);
    logic [9:0] sum;
    sum = {2'b00, a} + {9'd0, b} + {9'd0, c};
    return (sum > 10'd255) ? 8'hFF : sum[7:0];
  endfunction

  logic [7:0] errcnt_q;

  always_ff @(posedge clk) begin
    if (reset) errcnt_q <= 8'h00;
    else       errcnt_q <= sat_add(errcnt_q, err_evt, ovf_evt);
  end

  assign err_count = errcnt_q;
`else
  assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_noc_cmd_parser.sv
// Scoreboard bench for noc_cmd_parser: a frame-level reference model predicts requests and error pulses,
// and a negedge monitor compares them against the DUT handshakes.
module tb_noc_cmd_parser;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ctl = 1'b1;
  logic [7:0] data = 8'h00;
  logic       wr_ready = 1'b0, rd_ready = 1'b0;
  logic       wr_valid, rd_valid, frame_err, fifo_ovf;
  logic [7:0] wr_addr, wr_data, rd_addr, err_count;
  logic [3:0] rd_len;

  always #5 clk = ~clk;

  noc_cmd_parser #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .noc_to_dev_ctl(ctl), .noc_to_dev_data(data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_len(rd_len),
    .frame_err(frame_err), .fifo_ovf(fifo_ovf), .err_count(err_count)
  );

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  typedef struct { logic [7:0] a; logic [3:0] l; } rd_t;

  wr_t exp_wr[$];
  rd_t exp_rd[$];
  bit  err_at[int];
  int  total = 0, bad = 0, cyc = 0;
  int  ovf_cyc = -1, ec = 0, occ = 0;
  bit  rd_pend = 0, mon_en = 0;
  // Frame position: 0 idle, 1 awaiting read address, 2 awaiting write address, 3 write payload.
  int  m_mode = 0, m_len = 1, m_idx = 0, m_base = 0;
  int  wr_pct = 100, rd_pct = 100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_ec();
`ifdef NOC_PARSER_ERRCNT_EN
    chk("err_count", err_count, ec);
`else
    chk("err_count", err_count, 0);
`endif
  endtask

  // Reference model: consumes one NOC byte that the DUT samples at the coming edge.
  task automatic model_step(input bit c, input logic [7:0] d);
    bit pop, rdacc, errs, ovfe, loaded;
    int op;
    pop = (occ > 0) && wr_ready;
    rdacc = rd_pend && rd_ready;
    errs = 0; ovfe = 0; loaded = 0;
    if (c) begin
      if (m_mode != 0) errs = 1;
      op = int'(d[7:5]);
      m_mode = 0;
      if (op == 1 || op == 2) begin
        m_mode = (op == 1) ? 1 : 2;
        m_len = 1 << d[1:0];
      end else if (op != 0) errs = 1;
    end else begin
      case (m_mode)
        0: errs = 1;
        1: begin
          if (rd_pend && !rd_ready) errs = 1;
          else begin
            exp_rd.push_back('{a: d, l: 4'(m_len)});
            loaded = 1;
          end
          m_mode = 0;
        end
        2: begin m_base = int'(d); m_idx = 0; m_mode = 3; end
        default: begin
          if (occ < DEPTH || pop) begin
            exp_wr.push_back('{a: 8'((m_base + m_idx) % 256), d: d});
            occ++;
          end else ovfe = 1;
          m_idx++;
          if (m_idx == m_len) m_mode = 0;
        end
      endcase
    end
    if (pop) occ--;
    rd_pend = (rd_pend && !rdacc) || loaded;
    if (errs) err_at[cyc + 1] = 1;
    if (ovfe && ovf_cyc < 0) ovf_cyc = cyc + 1;
    ec = ec + int'(errs) + int'(ovfe);
    if (ec > 255) ec = 255;
  endtask

  task automatic send(input bit c, input logic [7:0] d);
    ctl = c;
    data = d;
    wr_ready = ($urandom_range(1, 100) <= wr_pct);
    rd_ready = ($urandom_range(1, 100) <= rd_pct);
    model_step(c, d);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; ctl = 1'b1; data = 8'h00; wr_ready = 1'b0; rd_ready = 1'b0;
    exp_wr.delete(); exp_rd.delete();
    occ = 0; rd_pend = 0; m_mode = 0; ovf_cyc = -1; ec = 0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      wr_t w;
      rd_t r;
      chk("frame_err", frame_err, err_at.exists(cyc));
      chk("fifo_ovf", fifo_ovf, (ovf_cyc >= 0 && cyc >= ovf_cyc));
      if (wr_valid && wr_ready) begin
        if (exp_wr.size() == 0) begin
          total++; bad++;
          $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write", wr_addr, wr_data);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_addr", wr_addr, w.a);
          chk("wr_data", wr_data, w.d);
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          total++; bad++;
          $display("FAIL rd_unexpected: got addr 0x%0h len %0d expected no read", rd_addr, rd_len);
        end else begin
          r = exp_rd.pop_front();
          chk("rd_addr", rd_addr, r.a);
          chk("rd_len", rd_len, r.l);
        end
      end
    end
  end

  initial begin
    logic [7:0] cmd;
    int n, lim, k, guard;
    @(posedge clk); #1;
    do_reset();
    mon_en = 1;
    chk("rst_wr_valid", wr_valid, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_fifo_ovf", fifo_ovf, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_err_count", err_count, 0);

    // Four-byte write drained immediately.
    send(1, 8'h42); send(0, 8'h10);
    for (int i = 0; i < 4; i++) send(0, 8'hA0 + 8'(i));
    repeat (3) send(1, 8'h00);

    // Read held off by the core; a second read must be dropped.
    rd_pct = 0;
    send(1, 8'h23); send(0, 8'h80);
    chk("rd_valid_held", rd_valid, 1);
    chk("rd_addr_first", rd_addr, 8'h80);
    chk("rd_len_first", rd_len, 8);
    send(1, 8'h20); send(0, 8'h05);
    chk("rd_addr_kept", rd_addr, 8'h80);
    chk("rd_len_kept", rd_len, 8);
    rd_pct = 100;
    repeat (3) send(1, 8'h00);

    // Eight-byte write into a stalled four-entry FIFO.
    do_reset();
    wr_pct = 0;
    send(1, 8'h43); send(0, 8'h30);
    for (int i = 0; i < 8; i++) send(0, 8'($urandom));
    chk("ovf_after_len8", fifo_ovf, 1);
`ifdef NOC_PARSER_ERRCNT_EN
    chk("err_count_4drops", err_count, 4);
`else
    chk("err_count_tied", err_count, 0);
`endif
    send(0, 8'h77);
    chk_ec();
    wr_pct = 100;
    repeat (6) send(1, 8'h00);

    // Wrapping write aborted by a READ command, whose address is then accepted.
    send(1, 8'h42); send(0, 8'hFE); send(0, 8'h11); send(0, 8'h22);
    send(1, 8'h20); send(0, 8'h40);
    repeat (3) send(1, 8'h00);

    // Stray data byte and illegal opcode.
    send(0, 8'h55); send(1, 8'hE0);
    repeat (2) send(1, 8'h00);
    chk_ec();

    // Reset in the middle of a write payload.
    wr_pct = 0;
    send(1, 8'h42); send(0, 8'h50); send(0, 8'h01); send(0, 8'h02);
    do_reset();
    chk("mid_rst_wr_valid", wr_valid, 0);
    chk("mid_rst_fifo_ovf", fifo_ovf, 0);
    wr_pct = 100;
    send(1, 8'h41); send(0, 8'h60); send(0, 8'hC1); send(0, 8'hC2);
    repeat (3) send(1, 8'h00);

    // Randomized frame mix with varying backpressure.
    rd_pct = 50;
    for (int f = 0; f < 400; f++) begin
      k = (f / 40) % 3;
      wr_pct = (k == 0) ? 100 : ((k == 1) ? 60 : 15);
      k = $urandom_range(0, 9);
      if (k <= 3) begin
        cmd = {3'b010, 3'($urandom), 2'($urandom)};
        n = 1 << cmd[1:0];
        lim = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : n;
        send(1, cmd); send(0, 8'($urandom));
        for (int i = 0; i < lim; i++) send(0, 8'($urandom));
      end else if (k <= 5) begin
        send(1, {3'b001, 3'($urandom), 2'($urandom)});
        if ($urandom_range(0, 7) != 0) send(0, 8'($urandom));
      end else if (k == 6) begin
        send(1, {3'($urandom_range(3, 7)), 5'($urandom)});
      end else if (k == 7) begin
        send(0, 8'($urandom));
      end else begin
        send(1, 8'h00);
      end
    end
    chk_ec();

    // Drain everything that is still expected.
    wr_pct = 100; rd_pct = 100;
    guard = 0;
    while ((exp_wr.size() != 0 || exp_rd.size() != 0) && guard < 60) begin
      send(1, 8'h00);
      guard++;
    end
    send(1, 8'h00);
    chk("drain_wr_left", exp_wr.size(), 0);
    chk("drain_rd_left", exp_rd.size(), 0);
    chk("drain_wr_valid", wr_valid, 0);
    chk("drain_rd_valid", rd_valid, 0);
    chk_ec();

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/noc_cmd_parser.md
# noc_cmd_parser

Receive-side command parser on the NOC-to-device path. It consumes the byte stream on `noc_to_dev_ctl`/`noc_to_dev_data` and decodes command frames into two outputs: a buffered write-request stream and a single-entry read-request register, both handed to the device core over valid/ready handshakes. It sits directly downstream of the NOC `TO` driver and upstream of the device register logic. The NOC side has no backpressure, so the parser never stalls the NOC.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: write-request FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `clk`, in, 1: the single clock; everything is rising-edge.
- `reset`, in, 1: synchronous, active-high.
- `noc_to_dev_ctl`, in, 1: 1 means the byte is a command byte; 0 means it is an address or payload byte.
- `noc_to_dev_data`, in, 8: NOC byte, sampled every cycle.
- `wr_valid`, out, 1: the FIFO head holds a write request.
- `wr_ready`, in, 1: the core accepts the head entry.
- `wr_addr`, out, 8: address of the head entry.
- `wr_data`, out, 8: data of the head entry.
- `rd_valid`, out, 1: a read request is pending.
- `rd_ready`, in, 1: the core accepts the read request.
- `rd_addr`, out, 8: base address of the read.
- `rd_len`, out, 4: read byte count, one of 1, 2, 4 or 8.
- `frame_err`, out, 1: one-cycle pulse on a protocol error.
- `fifo_ovf`, out, 1: sticky flag, set when a write byte is dropped; cleared only by reset.
- `err_count`, out, 8: saturating error counter (see Configuration).

## Operation
Command byte format (ctl=1):
- Bits [7:5] are the opcode: 000 = NOP, 001 = READ, 010 = WRITE. Any other value is illegal.
- Bits [1:0] are the length code; length = 1 << code, giving 1, 2, 4 or 8 bytes.
- Bits [4:2] are ignored.
- The NOC idles with ctl=1, data=0x00 (NOP).

Frames:
- READ: command byte, then one address byte (ctl=0).
- WRITE: command byte, then one address byte, then exactly `len` data bytes (ctl=0).

States and transitions:
- IDLE:
  - READ or WRITE command: latch opcode and length, go to ADDR.
  - NOP: stay in IDLE.
  - Illegal opcode: pulse `frame_err`, stay in IDLE.
  - ctl=0 byte: pulse `frame_err`, discard the byte, stay in IDLE.
- ADDR, on a ctl=0 byte:
  - Latch it as the base address.
  - For READ: load `rd_addr`/`rd_len`, set `rd_valid`, go to IDLE.
  - For WRITE: clear the byte index, go to WDATA.
- WDATA, on each ctl=0 byte:
  - Push {base + index (mod 256), byte} into the FIFO.
  - Increment the index; after the `len`-th byte, go to IDLE.
- A ctl=1 byte arriving in ADDR or WDATA:
  - Pulse `frame_err` and abort the current frame. Bytes already pushed remain in the FIFO.
  - Decode that same byte as a new command, using the IDLE rules, in the same cycle.

Read and write handling:
- The read register holds one entry. If a READ address byte completes while `rd_valid`=1 and `rd_ready`=0, the new request is dropped, `frame_err` pulses, and the old request is kept.
- If `rd_valid`=1 and `rd_ready`=1 in the same cycle that a new read completes, the new request is loaded (no error).
- A write byte arriving while the FIFO is full is dropped and sets `fifo_ovf`. The index still advances, so the frame length is kept.
- If the FIFO is full but a pop happens in the same cycle (`wr_valid` and `wr_ready`), the push is accepted.
- Address arithmetic is 8-bit and wraps: base 0xFE with length 4 gives addresses 0xFE, 0xFF, 0x00, 0x01.

## Timing
- All outputs are registered.
- Reset values: `wr_valid`, `rd_valid`, `frame_err`, `fifo_ovf` = 0; `wr_addr`, `wr_data`, `rd_addr` = 0x00; `rd_len` = 0; `err_count` = 0. State returns to IDLE and the FIFO is emptied.
- Reset has priority over all other inputs. Asserting it mid-frame discards the frame and all queued writes.
- A data byte sampled at edge N is visible at the FIFO head (`wr_valid`=1) after edge N, if the FIFO was empty.
- A READ address byte sampled at edge N gives `rd_valid`=1 after edge N.
- `frame_err` is high for exactly the cycle after the offending byte.
- A handshake completes when valid and ready are both high at a rising edge. Valid stays high and the payload stays stable until acceptance.
- Throughput: one NOC byte per cycle, sustained, with no bubbles.

## Configuration
Macro `NOC_PARSER_ERRCNT_EN`.
- Defined: `err_count` increments by 1 on every `frame_err` pulse and on every `fifo_ovf` drop event. A single cycle with both events counts +2. The counter saturates at 0xFF.
- Undefined: no counter register is built and `err_count` is tied to 0x00.
- All other behaviour is identical in both builds.

## Test plan
- WRITE len code 2 (0x42), address 0x10, data 0xA0 0xA1 0xA2 0xA3, `wr_ready`=1 -> four pops with addresses 0x10 to 0x13 and data 0xA0 to 0xA3, in order; `frame_err` stays 0.
- READ 0x23 (len 8), address 0x80, with `rd_ready` held at 0 -> `rd_valid`=1, `rd_addr`=0x80, `rd_len`=8, held stable; a second READ 0x20 to 0x05 -> dropped, one `frame_err` pulse, `rd_addr` still 0x80.
- WRITE len 8, `wr_ready`=0, `FIFO_DEPTH`=4 -> four entries queued, `fifo_ovf`=1 after the 5th byte, state returns to IDLE after the 8th byte; with the macro defined, `err_count`=4.
- WRITE len 4 to address 0xFE, with a command byte 0x20 injected after 2 data bytes -> `frame_err` pulse, FIFO holds 0xFE and 0xFF, and the parser then accepts the 0x20 READ's address byte.
- ctl=0 byte 0x55 while idle, then illegal command 0xE0 -> two `frame_err` pulses, no requests issued.
- Reset asserted in WDATA with 2 entries queued -> next cycle `wr_valid`=0 and `fifo_ovf`=0, state IDLE; a following frame decodes correctly.
